// File: rtl/access_record_packer.sv
// Packs two {info, address} records into one queue word (lower half first); optional PACKER_FLUSH_EN pads a lone record out.
// Latency: the word is written the cycle after its second record is taken; a flushed half is written the cycle after the flush edge.
// Backpressure: waitrequest holds write_en/data_in; in_ready drops only while a half is buffered behind a pending word.
module access_record_packer #(
   parameter int INFO_WIDTH   = 10,
   parameter int ADDR_WIDTH   = 32,
   parameter int Q_DATA_WIDTH = 128,
   parameter logic [Q_DATA_WIDTH/2-1:0] PAD_VALUE = '0,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   input  logic [INFO_WIDTH+ADDR_WIDTH-1:0] in_data,
   output logic                             in_ready,
   input  logic                             flush,
   output logic                             write_en,
   output logic [Q_DATA_WIDTH-1:0]          data_in,
   input  logic                             waitrequest,
   output logic [CNT_WIDTH-1:0]             words_written,
   output logic                             half_pending
);

   localparam int HALF_W = Q_DATA_WIDTH / 2;

   logic              half_valid;
   logic              word_valid;
   logic [HALF_W-1:0] half_q;
   logic [HALF_W-1:0] in_half;
   logic              take;
   logic              accept;
   logic              pair;
   logic              promote;

   assign in_half  = HALF_W'(in_data);
   // Pure register decode: no path from waitrequest into in_ready.
   assign in_ready = ~(half_valid & word_valid);
   assign take     = in_valid & in_ready;
   assign accept   = word_valid & ~waitrequest;
   // in_ready guarantees the output slot is empty whenever a pair forms.
   assign pair     = take & half_valid;

`ifdef PACKER_FLUSH_EN
   assign promote = flush & half_valid & ~word_valid & ~take;
`else
   logic unused_cfg;
   assign unused_cfg = ^{flush, PAD_VALUE};
   assign promote    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         half_valid    <= 1'b0;
         word_valid    <= 1'b0;
         half_q        <= '0;
         data_in       <= '0;
         words_written <= '0;
      end else begin
         if (accept) begin
            word_valid    <= 1'b0;
            words_written <= words_written + CNT_WIDTH'(1);
         end
         if (take && !half_valid) begin
            half_q     <= in_half;
            half_valid <= 1'b1;
         end else if (pair) begin
            data_in    <= {in_half, half_q};
            word_valid <= 1'b1;
            half_valid <= 1'b0;
         end else if (promote) begin
            data_in    <= {PAD_VALUE, half_q};
            word_valid <= 1'b1;
            half_valid <= 1'b0;
         end
      end
   end

   assign write_en     = word_valid;
   assign half_pending = half_valid;

endmodule

// File: tb/tb_access_record_packer.sv
// Directed bench for access_record_packer: reset, pairing, streaming, retry, flush and reset-during-retry.
module tb_access_record_packer;

   localparam int IW = 10;
   localparam int AW = 32;
   localparam int QW = 128;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [IW+AW-1:0] in_data = '0;
   logic          in_ready;
   logic          flush = 1'b0;
   logic          write_en;
   logic [QW-1:0] data_in;
   logic          waitrequest = 1'b0;
   logic [CW-1:0] words_written;
   logic          half_pending;

   int tests = 0;
   int fails = 0;
   logic [QW-1:0] mon_q[$];

   access_record_packer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .flush(flush), .write_en(write_en),
      .data_in(data_in), .waitrequest(waitrequest),
      .words_written(words_written), .half_pending(half_pending)
   );

   always #5 clk = ~clk;

   // Inputs change just after posedge, so negedge shows what the next edge accepts.
   always @(negedge clk) if (rst && write_en && !waitrequest) mon_q.push_back(data_in);

   function automatic logic [63:0] h(input logic [IW-1:0] info, input logic [AW-1:0] a);
      return {22'b0, info, a};
   endfunction

   task automatic send(input logic [IW-1:0] info, input logic [AW-1:0] a);
      bit ok = 0;
      in_valid = 1'b1;
      in_data  = {info, a};
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         tests++; fails++;
         $display("FAIL send_timeout: record %h not taken within 50 cycles", {info, a});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_pair;
      logic [QW-1:0] exp;
      mon_q.delete();
      waitrequest = 1'b0;
      send(10'h3C8, 32'h0000_0000);
      send(10'h3C8, 32'h0FFF_FFFF);
      idle(3);
      exp = {h(10'h3C8, 32'h0FFF_FFFF), h(10'h3C8, 32'h0)};
      tests++;
      if (mon_q.size() != 1) begin
         fails++; $display("FAIL pair_count: got %0d writes, want 1", mon_q.size());
      end else begin
         tests++;
         if (mon_q[0] !== exp) begin
            fails++; $display("FAIL pair_word: got %h want %h", mon_q[0], exp);
         end
      end
      tests++;
      if (words_written !== 16'd1) begin
         fails++; $display("FAIL pair_cnt: got %0d want 1", words_written);
      end
   endtask

   task automatic test_reset;
      waitrequest = 1'b1;
      send(10'h001, 32'hA);
      send(10'h002, 32'hB);
      send(10'h003, 32'hC);
      #1 rst = 1'b0;
      #1;
      tests++;
      if (write_en !== 1'b0 || data_in !== '0 || words_written !== '0 || half_pending !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: we=%b data=%h cnt=%0d hp=%b want 0/0/0/0",
                  write_en, data_in, words_written, half_pending);
      end
      idle(2);
      rst = 1'b1;
      waitrequest = 1'b0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
      end
      @(posedge clk); #1;
      mon_q.delete();
   endtask

   task automatic test_back_to_back;
      int not_ready = 0;
      int bad = 0;
      logic [QW-1:0] exp;
      mon_q.delete();
      waitrequest = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         in_data = {10'h155, 32'(i)};
         @(negedge clk);
         if (!in_ready) not_ready++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      idle(3);
      tests++;
      if (not_ready != 0) begin
         fails++; $display("FAIL b2b_ready: in_ready low %0d cycles, want 0", not_ready);
      end
      tests++;
      if (mon_q.size() != 512) begin
         fails++; $display("FAIL b2b_count: got %0d writes, want 512", mon_q.size());
      end else begin
         for (int j = 0; j < 512; j++) begin
            exp = {h(10'h155, 32'(2*j+1)), h(10'h155, 32'(2*j))};
            if (mon_q[j] !== exp && bad == 0) begin
               bad++; $display("FAIL b2b_word: word %0d got %h want %h", j, mon_q[j], exp);
            end
         end
         tests++;
         if (bad != 0) fails++;
      end
      tests++;
      if (words_written !== 16'd512) begin
         fails++; $display("FAIL b2b_cnt: got %0d want 512", words_written);
      end
   endtask

   task automatic test_waitrequest;
      logic [QW-1:0] exp_ab, exp_dc;
      int bad = 0;
      exp_ab = {h(10'h0A2, 32'h2000_0002), h(10'h0A1, 32'h1000_0001)};
      exp_dc = {h(10'h0A4, 32'h4000_0004), h(10'h0A3, 32'h3000_0003)};
      mon_q.delete();
      waitrequest = 1'b1;
      send(10'h0A1, 32'h1000_0001);
      send(10'h0A2, 32'h2000_0002);
      tests++;
      if (write_en !== 1'b1 || data_in !== exp_ab) begin
         fails++; $display("FAIL wr_pending: we=%b data=%h want 1/%h", write_en, data_in, exp_ab);
      end
      send(10'h0A3, 32'h3000_0003);
      tests++;
      if (half_pending !== 1'b1) begin
         fails++; $display("FAIL wr_third_buffered: half_pending=%b want 1", half_pending);
      end
      in_valid = 1'b1;
      in_data  = {10'h0A4, 32'h4000_0004};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || write_en !== 1'b1 || data_in !== exp_ab) bad++;
         @(posedge clk); #1;
      end
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL wr_hold: %0d cycles with in_ready/write_en/data_in wrong, want 0", bad);
      end
      waitrequest = 1'b0;
      send(10'h0A4, 32'h4000_0004);
      idle(3);
      tests++;
      if (mon_q.size() != 2 || mon_q[0] !== exp_ab || mon_q[1] !== exp_dc) begin
         fails++; $display("FAIL wr_release: got %0d writes, want exactly %h then %h",
                           mon_q.size(), exp_ab, exp_dc);
      end
      tests++;
      if (words_written !== 16'd514) begin
         fails++; $display("FAIL wr_cnt: got %0d want 514", words_written);
      end
   endtask

   task automatic test_flush;
      mon_q.delete();
      waitrequest = 1'b0;
      send(10'h000, 32'h0000_0600);
      flush = 1'b1;
      idle(4);
      flush = 1'b0;
      idle(1);
`ifdef PACKER_FLUSH_EN
      tests++;
      if (mon_q.size() != 1 || mon_q[0] !== {64'h0, h(10'h000, 32'h600)}) begin
         fails++; $display("FAIL flush_word: got %0d writes, want one of %h", mon_q.size(),
                           {64'h0, h(10'h000, 32'h600)});
      end
      tests++;
      if (half_pending !== 1'b0) begin
         fails++; $display("FAIL flush_half: half_pending=%b want 0", half_pending);
      end
`else
      tests++;
      if (mon_q.size() != 0) begin
         fails++; $display("FAIL noflush_write: got %0d writes, want 0", mon_q.size());
      end
      tests++;
      if (half_pending !== 1'b1) begin
         fails++; $display("FAIL noflush_half: half_pending=%b want 1", half_pending);
      end
`endif
   endtask

   task automatic test_reset_retry;
      logic [QW-1:0] exp;
      exp = {h(10'h0F2, 32'hBEEF_0002), h(10'h0F1, 32'hBEEF_0001)};
      rst = 1'b0; idle(1); rst = 1'b1; idle(1);
      waitrequest = 1'b1;
      send(10'h011, 32'h1);
      send(10'h012, 32'h2);
      idle(1);
      #1 rst = 1'b0;
      #1;
      tests++;
      if (write_en !== 1'b0) begin
         fails++; $display("FAIL retry_reset_we: write_en=%b want 0", write_en);
      end
      idle(2);
      rst = 1'b1;
      waitrequest = 1'b0;
      mon_q.delete();
      send(10'h0F1, 32'hBEEF_0001);
      send(10'h0F2, 32'hBEEF_0002);
      idle(3);
      tests++;
      if (mon_q.size() != 1 || mon_q[0] !== exp) begin
         fails++; $display("FAIL retry_fresh_word: got %0d writes, want one of %h", mon_q.size(), exp);
      end
      tests++;
      if (words_written !== 16'd1) begin
         fails++; $display("FAIL retry_cnt: got %0d want 1", words_written);
      end
   endtask

   initial begin
      idle(3);
      rst = 1'b1;
      idle(1);
      test_pair();
      test_reset();
      test_back_to_back();
      test_waitrequest();
      test_flush();
      test_reset_retry();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
